// File: rtl/rat_pipe_pkg.sv
// rtl/rat_pipe_pkg.sv - shared types and constants for the RAT pipeline interrupt path
// Contents: int_state_t (interrupt sequencer states), RAT_INT_VECTOR (default vector address)
package rat_pipe_pkg;

    typedef enum logic [1:0] {
        IS_IDLE,
        IS_DRAIN,
        IS_INJECT,
        IS_VECTOR
    } int_state_t;

    localparam logic [9:0] RAT_INT_VECTOR = 10'h3F;

endpackage

// File: rtl/int_sequencer_if.sv
// rtl/int_sequencer_if.sv - signal bundle between the CPU pipeline and the interrupt sequencer
// master: pipeline side (drives irq_in/i_flag/mem_stall/ex_branch_taken, receives control)
// slave:  sequencer side (receives requests/status, drives stall/inject/vector control)
interface int_sequencer_if #(
    parameter int ADDR_W = 10
);
    logic              irq_in;
    logic              i_flag;
    logic              mem_stall;
    logic              ex_branch_taken;
    logic              irq_pending;
    logic              busy;
    logic              fetch_stall;
    logic              dec_nop;
    logic              dec_int;
    logic              vec_sel;
    logic              pc_load;
    logic [ADDR_W-1:0] vec_addr;
    logic              int_ack;

    modport master (
        output irq_in, i_flag, mem_stall, ex_branch_taken,
        input  irq_pending, busy, fetch_stall, dec_nop, dec_int,
               vec_sel, pc_load, vec_addr, int_ack
    );

    modport slave (
        input  irq_in, i_flag, mem_stall, ex_branch_taken,
        output irq_pending, busy, fetch_stall, dec_nop, dec_int,
               vec_sel, pc_load, vec_addr, int_ack
    );
endinterface

// File: rtl/irq_sync.sv
// rtl/irq_sync.sv - two-flop synchroniser with rising-edge detect for the external interrupt
// Ports: clk, rst (sync, active-high), irq_in (async raw request), irq_edge (one-cycle pulse per rise)
module irq_sync (
    input  logic clk,
    input  logic rst,
    input  logic irq_in,
    output logic irq_edge
);
    logic s1;
    logic s2;
    logic s2_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            s2_d <= 1'b0;
        end else begin
            s1   <= irq_in;
            s2   <= s1;
            s2_d <= s2;
        end
    end

    // A level-held request produces exactly one pulse.
    assign irq_edge = s2 & ~s2_d;
endmodule

// File: rtl/int_sequencer.sv
// rtl/int_sequencer.sv - interrupt entry sequencer: drain fetch/decode, inject INT, steer PC to vector
// Ports: clk, rst (sync, active-high), bus (int_sequencer_if.slave: irq_in, i_flag, mem_stall,
//        ex_branch_taken in; irq_pending, busy, fetch_stall, dec_nop, dec_int, vec_sel, pc_load,
//        vec_addr, int_ack out)
module int_sequencer
    import rat_pipe_pkg::*;
#(
    parameter int              ADDR_W       = 10,
    parameter logic [ADDR_W-1:0] VECTOR_ADDR = ADDR_W'(RAT_INT_VECTOR),
    parameter int              DRAIN_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    int_sequencer_if.slave  bus
);
    localparam int CNT_W = $clog2(DRAIN_CYCLES + 1);

    int_state_t       state_q;
    int_state_t       state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             pending_q;
    logic             irq_edge;
    logic             ack;

    irq_sync u_irq_sync (
        .clk      (clk),
        .rst      (rst),
        .irq_in   (bus.irq_in),
        .irq_edge (irq_edge)
    );

    assign ack = (state_q == IS_INJECT);

    // A new edge in the acknowledge cycle must survive, so set has priority over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending_q <= 1'b0;
        end else if (irq_edge) begin
            pending_q <= 1'b1;
        end else if (ack) begin
            pending_q <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IS_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IS_IDLE: begin
                if (pending_q && bus.i_flag && !bus.mem_stall) begin
                    state_d = IS_DRAIN;
                    cnt_d   = CNT_W'(DRAIN_CYCLES - 1);
                end
            end
            IS_DRAIN: begin
                // i_flag is deliberately not looked at here: the entry is already committed.
                // A branch resolving on the last bubble holds one more cycle so the pushed
                // return address is the branch target rather than the stale fall-through PC.
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else if (!bus.ex_branch_taken) begin
                    state_d = IS_INJECT;
                end else begin
                    cnt_d = '0;
                end
            end
            IS_INJECT: state_d = IS_VECTOR;
            IS_VECTOR: state_d = IS_IDLE;
            default:   state_d = IS_IDLE;
        endcase
    end

    always_comb begin
        bus.fetch_stall = 1'b0;
        bus.dec_nop     = 1'b0;
        bus.dec_int     = 1'b0;
        bus.vec_sel     = 1'b0;
        bus.pc_load     = 1'b0;
        bus.int_ack     = 1'b0;
        case (state_q)
            IS_DRAIN: begin
                bus.fetch_stall = 1'b1;
                bus.dec_nop     = 1'b1;
            end
            IS_INJECT: begin
                bus.fetch_stall = 1'b1;
                bus.dec_int     = 1'b1;
                bus.int_ack     = 1'b1;
            end
            IS_VECTOR: begin
                bus.vec_sel = 1'b1;
                bus.pc_load = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.irq_pending = pending_q;
    assign bus.busy        = (state_q != IS_IDLE);
    assign bus.vec_addr    = VECTOR_ADDR;
endmodule

// File: tb/tb_int_sequencer.sv
// tb/tb_int_sequencer.sv - self-checking bench for int_sequencer with a cycle-level reference model
module tb_int_sequencer;
    localparam int DRAIN = 2;
    localparam int PH_IDLE = 0, PH_DRAIN = 1, PH_INJ = 2, PH_VEC = 3;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // reference model state
    bit   hist [3];
    bit   m_pend;
    int   m_phase;
    int   m_drained;

    int_sequencer_if #(.ADDR_W(10)) bus ();

    int_sequencer #(.ADDR_W(10), .VECTOR_ADDR(10'h3F), .DRAIN_CYCLES(DRAIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] dut_vec();
        return {14'd0, bus.irq_pending, bus.busy, bus.fetch_stall, bus.dec_nop, bus.dec_int,
                bus.vec_sel, bus.pc_load, bus.int_ack, bus.vec_addr};
    endfunction

    function automatic logic [31:0] model_vec();
        logic in_d, in_i, in_v;
        in_d = (m_phase == PH_DRAIN);
        in_i = (m_phase == PH_INJ);
        in_v = (m_phase == PH_VEC);
        return {14'd0, m_pend, m_phase != PH_IDLE, in_d | in_i, in_d, in_i, in_v, in_v, in_i, 10'h3F};
    endfunction

    // One clock: advance the model with the inputs present at the edge, then compare.
    task automatic step();
        bit edge_now, ack;
        @(posedge clk);
        if (rst) begin
            hist = '{0, 0, 0};
            m_pend = 0; m_phase = PH_IDLE; m_drained = 0;
        end else begin
            edge_now = hist[1] & ~hist[2];
            ack = (m_phase == PH_INJ);
            case (m_phase)
                PH_IDLE:
                    if (m_pend && bus.i_flag && !bus.mem_stall) begin
                        m_phase = PH_DRAIN; m_drained = 1;
                    end
                PH_DRAIN:
                    if (m_drained < DRAIN) m_drained++;
                    else if (!bus.ex_branch_taken) m_phase = PH_INJ;
                PH_INJ: m_phase = PH_VEC;
                default: m_phase = PH_IDLE;
            endcase
            m_pend = edge_now | (m_pend & ~ack);
            hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = bus.irq_in;
        end
        #1;
        chk("model", dut_vec(), model_vec());
    endtask

    task automatic pulse_irq();
        bus.irq_in = 1'b1;
        step();
        bus.irq_in = 1'b0;
    endtask

    initial begin
        int rise, nops, acks, vecs, ints;
        rst = 1'b1;
        bus.irq_in = 0; bus.i_flag = 0; bus.mem_stall = 0; bus.ex_branch_taken = 0;
        step(); step();
        chk("reset_outs", dut_vec(), {22'd0, 10'h3F});
        rst = 1'b0;

        // 1: held request, full entry sequence
        bus.i_flag = 1; bus.irq_in = 1;
        rise = 0; nops = 0; acks = 0; vecs = 0;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (i == 5) bus.irq_in = 0;
            if (bus.irq_pending && rise == 0) rise = i;
            nops += bus.dec_nop; acks += bus.int_ack; vecs += (bus.vec_sel & bus.pc_load);
        end
        chk("t1_pend_latency", rise, 3);
        chk("t1_drain_cycles", nops, DRAIN);
        chk("t1_acks", acks, 1);
        chk("t1_vectors", vecs, 1);
        chk("t1_idle", {bus.busy, bus.irq_pending}, 2'b00);

        // 2: masked request waits
        bus.i_flag = 0;
        pulse_irq();
        for (int i = 0; i < 20; i++) step();
        chk("t2_held", {bus.busy, bus.irq_pending}, 2'b01);
        bus.i_flag = 1;
        step();
        chk("t2_start", bus.busy, 1);
        for (int i = 0; i < 8; i++) step();

        // 3: branch on last drain cycle
        pulse_irq();
        for (int k = 0; k < 10 && !bus.dec_nop; k++) step();
        chk("t3_wait_drain", bus.dec_nop, 1);
        step();
        bus.ex_branch_taken = 1;
        step();
        chk("t3_extra_drain", {bus.dec_nop, bus.dec_int}, 2'b10);
        bus.ex_branch_taken = 0;
        step();
        chk("t3_inject", {bus.dec_nop, bus.dec_int}, 2'b01);
        for (int i = 0; i < 5; i++) step();

        // 4: second edge lands in INJECT
        pulse_irq();
        for (int k = 0; k < 10 && !bus.dec_nop; k++) step();
        chk("t4_wait_drain", bus.dec_nop, 1);
        bus.irq_in = 1;
        step();
        bus.irq_in = 0;
        step();
        chk("t4_inject", bus.int_ack, 1);
        step();
        chk("t4_repend", bus.irq_pending, 1);
        ints = 0;
        for (int i = 0; i < 12; i++) begin step(); ints += bus.dec_int; end
        chk("t4_second_entry", ints, 1);

        // 5: mem_stall holds entry
        bus.mem_stall = 1;
        pulse_irq();
        for (int i = 0; i < 8; i++) step();
        chk("t5_held", {bus.busy, bus.irq_pending}, 2'b01);
        bus.mem_stall = 0;
        step();
        chk("t5_start", bus.busy, 1);
        for (int i = 0; i < 6; i++) step();

        // 6: reset during INJECT
        pulse_irq();
        for (int k = 0; k < 12 && !bus.dec_int; k++) step();
        chk("t6_wait_inject", bus.dec_int, 1);
        rst = 1;
        step();
        chk("t6_reset_outs", dut_vec(), {22'd0, 10'h3F});
        rst = 0;

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            bus.irq_in          = ($urandom_range(0, 7) == 0);
            bus.i_flag          = ($urandom_range(0, 3) != 0);
            bus.mem_stall       = ($urandom_range(0, 3) == 0);
            bus.ex_branch_taken = ($urandom_range(0, 2) == 0);
            rst                 = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
